// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, mid-bit sampling driven by a
// bit-timing counter, one-cycle data_valid / frame_err pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic [1:0]       settle;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             start_edge;

  // armed only rises once the synchronised line has been seen high after
  // reset, so a line that is already low at release cannot start a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      settle  <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      settle  <= {settle[0], 1'b1};
      if (settle[1] && rx_s) armed <= 1'b1;
    end
  end

  assign start_edge = armed && rx_d && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Returning to IDLE at mid-stop-bit leaves half a bit to catch
          // the next start edge of a back-to-back frame.
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed vector table, hand-written
// corner sequences and random frames checked by a pulse scoreboard.
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int HALF    = (CPB - 1) / 2;
  localparam int LAT     = 3 + HALF + 9 * CPB;
  localparam int N_VEC   = 7;
  localparam int N_RAND  = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Expected pulses: {1 = data_valid / 0 = frame_err, data_out after pulse}
  logic [8:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [7:0] model_dout;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         period;
    int         gap;
    logic       exp_valid;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[N_VEC];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; rx is left at the
  // stop level. Called on a negedge, so the first low edge is cyc+1.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int period);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rx = bits[j];
      wait_neg(period);
    end
  endtask

  task automatic expect_pulse(input logic is_valid, input logic [7:0] dout, input int k);
    exp_q.push_back({is_valid, dout});
    exp_cyc_q.push_back(k + LAT);
  endtask

  task automatic busy_probe(input int k);
    wait_until(k + 1);
    check("busy_before_start", busy, 1'b0);
    wait_until(k + 2);
    check("busy_rise", busy, 1'b1);
    wait_until(k + LAT - 1);
    check("busy_before_stop", busy, 1'b1);
    wait_until(k + LAT);
    check("busy_fall", busy, 1'b0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [8:0] e;
    int         c;
    if (rst_n && (data_valid || frame_err)) begin
      check("pulse_exclusive", data_valid & frame_err, 1'b0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: valid=%b ferr=%b data_out=%0h at cycle %0d, none expected",
                 data_valid, frame_err, data_out, cyc);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("pulse_kind_valid", data_valid, e[8]);
        check("pulse_cycle", cyc, c);
        check("pulse_data_out", data_out, e[7:0]);
      end
    end
  end

  initial begin
    int         k;
    logic [7:0] b;
    logic       s;
    int         gap;

    vecs[0] = '{8'hA5, 1'b1, 16, 20, 1'b1, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 16,  0, 1'b1, 8'h3C};
    vecs[2] = '{8'hFF, 1'b1, 16, 20, 1'b1, 8'hFF};
    vecs[3] = '{8'h5A, 1'b0, 16, 20, 1'b0, 8'hFF};
    vecs[4] = '{8'hC3, 1'b1, 15, 40, 1'b1, 8'hC3};
    vecs[5] = '{8'h00, 1'b1, 16, 20, 1'b1, 8'h00};
    vecs[6] = '{8'hC3, 1'b1, 17, 40, 1'b1, 8'hC3};

    rx    = 1'b1;
    rst_n = 1'b0;
    wait_neg(3);
    check("reset_data_out", data_out, 8'h00);
    check("reset_data_valid", data_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    model_dout = 8'h00;
    wait_neg(10);

    // directed vector table
    for (int i = 0; i < N_VEC; i++) begin
      k = cyc + 1;
      expect_pulse(vecs[i].exp_valid, vecs[i].exp_dout, k);
      model_dout = vecs[i].exp_dout;
      if (i == 0) begin
        fork
          send_frame(vecs[i].data, vecs[i].stop, vecs[i].period);
          busy_probe(k);
        join
      end else begin
        send_frame(vecs[i].data, vecs[i].stop, vecs[i].period);
      end
      rx = 1'b1;
      wait_neg(vecs[i].gap);
    end

    // framing error, then the line held low must not start a frame
    k = cyc + 1;
    expect_pulse(1'b0, model_dout, k);
    send_frame(8'h55, 1'b0, CPB);
    rx = 1'b0;
    wait_neg(300);
    check("hold_low_busy", busy, 1'b0);
    check("hold_low_data_out", data_out, model_dout);
    rx = 1'b1;
    wait_neg(20);

    // 4-cycle low glitch: START sample sees high and drops back to IDLE
    k = cyc + 1;
    rx = 1'b0;
    wait_neg(4);
    rx = 1'b1;
    wait_until(k + 2 + HALF);
    check("glitch_busy_in_start", busy, 1'b1);
    wait_until(k + 3 + HALF);
    check("glitch_busy_idle", busy, 1'b0);
    wait_neg(40);
    check("glitch_data_out", data_out, model_dout);

    // reset during bit 3 of 0x81 aborts the frame
    k = cyc + 1;
    fork
      send_frame(8'h81, 1'b1, CPB);
      begin
        wait_until(k + 4 * CPB + 6);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_data_out", data_out, 8'h00);
        check("midreset_valid", data_valid, 1'b0);
        check("midreset_ferr", frame_err, 1'b0);
        check("midreset_busy", busy, 1'b0);
      end
    join
    rx = 1'b1;
    model_dout = 8'h00;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(10);
    k = cyc + 1;
    expect_pulse(1'b1, 8'h81, k);
    model_dout = 8'h81;
    send_frame(8'h81, 1'b1, CPB);
    rx = 1'b1;
    wait_neg(20);

    // reset released with the line already low
    rx    = 1'b0;
    rst_n = 1'b0;
    wait_neg(3);
    model_dout = 8'h00;
    rst_n = 1'b1;
    wait_neg(200);
    check("low_release_busy", busy, 1'b0);
    check("low_release_data_out", data_out, 8'h00);
    rx = 1'b1;
    wait_neg(10);

    // random frames against the reference model
    for (int i = 0; i < N_RAND; i++) begin
      b   = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 30);
      if (!s && gap < 2) gap = 2;
      k = cyc + 1;
      if (s) model_dout = b;
      expect_pulse(s, model_dout, k);
      send_frame(b, s, CPB);
      rx = 1'b1;
      wait_neg(gap);
    end

    wait_neg(300);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_data_out", data_out, model_dout);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
